// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the single-port data SRAM: one RV32I request in flight,
// lane-aligned SRAM access, aligned and sign/zero-extended load result.
module mem_access_ctrl #(
  parameter int          AWIDTH    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              MEM_CSN,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [1:0]        lane_r;
  logic [AWIDTH-1:0] mem_addr_r;
  logic [3:0]        be_r;
  logic [31:0]       di_r;
  logic [31:0]       rdata_r;
  logic              err_r;

  logic [31:0]       offset_s;
  logic [3:0]        be_s;
  logic [31:0]       di_s;
  logic              illegal_s;
  logic              misalign_s;
  logic              oob_s;
  logic              req_err_s;

  // Select the addressed byte/half of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] dout,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = dout[{lane, 3'b000} +: 8];
    h = dout[{lane[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    load_extract = {{24{b[7]}}, b};
      F3_BU:   load_extract = {24'd0, b};
      F3_H:    load_extract = {{16{h[15]}}, h};
      F3_HU:   load_extract = {16'd0, h};
      F3_W:    load_extract = dout;
      default: load_extract = 32'd0;
    endcase
  endfunction

  // Request decode: lane enables, replicated store data and error detection.
  always_comb begin
    offset_s   = req_addr - BASE_ADDR;
    be_s       = 4'b0000;
    di_s       = req_wdata;
    illegal_s  = 1'b0;
    misalign_s = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: begin
        be_s = 4'b0001 << req_addr[1:0];
        di_s = {4{req_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be_s       = 4'b0011 << req_addr[1:0];
        di_s       = {2{req_wdata[15:0]}};
        misalign_s = req_addr[0];
      end
      F3_W: begin
        be_s       = 4'b1111;
        misalign_s = (req_addr[1:0] != 2'b00);
      end
      default: illegal_s = 1'b1;
    endcase
    // Addresses below BASE_ADDR wrap to large offsets and fail this test too.
    oob_s     = ((offset_s >> (AWIDTH + 2)) != 32'd0);
    req_err_s = illegal_s | misalign_s | oob_s | (req_we & req_funct3[2]);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = req_err_s ? RESP : ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Transaction and response registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      we_r       <= 1'b0;
      funct3_r   <= 3'b000;
      lane_r     <= 2'b00;
      mem_addr_r <= '0;
      be_r       <= 4'b0000;
      di_r       <= 32'd0;
      rdata_r    <= 32'd0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            if (req_err_s) begin
              err_r   <= 1'b1;
              rdata_r <= 32'd0;
            end else begin
              we_r       <= req_we;
              funct3_r   <= req_funct3;
              lane_r     <= req_addr[1:0];
              mem_addr_r <= offset_s[AWIDTH+1:2];
              be_r       <= req_we ? be_s : 4'b0000;
              di_r       <= di_s;
              err_r      <= 1'b0;
            end
          end
        end
        ACCESS: begin
          rdata_r <= we_r ? 32'd0 : load_extract(MEM_DOUT, funct3_r, lane_r);
          err_r   <= 1'b0;
        end
        default: begin
          rdata_r <= rdata_r;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only; SRAM is strobed solely in ACCESS.
  always_comb begin
    req_ready = (state_r == IDLE);
    rsp_valid = (state_r == RESP);
    rsp_rdata = rdata_r;
    rsp_err   = err_r;
    MEM_ADDR  = mem_addr_r;
    MEM_DI    = di_r;
    if (state_r == ACCESS) begin
      MEM_CSN = 1'b0;
      MEM_WEN = ~we_r;
      MEM_BE  = be_r;
    end else begin
      MEM_CSN = 1'b1;
      MEM_WEN = 1'b1;
      MEM_BE  = 4'b0000;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random traffic
// checked against a byte-addressed reference memory model.
module tb_mem_access_ctrl;

  localparam int          AW   = 12;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          MEM_CSN;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_WEN;
  logic [3:0]    MEM_BE;
  logic [31:0]   MEM_DI;
  logic [31:0]   MEM_DOUT;

  int compared   = 0;
  int mismatched = 0;
  int csn_low_cycles = 0;

  logic [31:0] sram    [0:(1<<AW)-1];
  logic [7:0]  ref_mem [0:(4<<AW)-1];

  mem_access_ctrl #(.AWIDTH(AW), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .MEM_CSN(MEM_CSN), .MEM_ADDR(MEM_ADDR),
    .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int l = 0; l < 4; l++) if (be[l]) w[8*l +: 8] = di[8*l +: 8];
    return w;
  endfunction

  // SRAM model: asynchronous read, falling-edge write.
  assign MEM_DOUT = sram[MEM_ADDR];
  always @(negedge CLK) begin
    if (MEM_CSN === 1'b0) csn_low_cycles <= csn_low_cycles + 1;
    if (MEM_CSN === 1'b0 && MEM_WEN === 1'b0) sram[MEM_ADDR] <= merge(sram[MEM_ADDR], MEM_DI, MEM_BE);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int msize(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit merr(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int s;
    logic [31:0] off;
    s   = msize(f3);
    off = addr - BASE;
    if (s == 0) return 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if ((addr % s) != 0) return 1'b1;
    return (off >= (32'd4 << AW));
  endfunction

  function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] addr);
    longint v;
    int s;
    logic [31:0] off;
    s = msize(f3);
    off = addr - BASE;
    v = 0;
    for (int i = 0; i < s; i++) v += longint'(ref_mem[off + i]) << (8 * i);
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * s - 1))) v -= longint'(1) << (8 * s);
    return v[31:0];
  endfunction

  function automatic logic [3:0] mbe(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] be;
    be = 4'b0000;
    for (int i = 0; i < msize(f3); i++) be[int'(addr[1:0]) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] mdi(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    for (int l = 0; l < 4; l++) d[8*l +: 8] = wdata[8*(l % msize(f3)) +: 8];
    return d;
  endfunction

  task automatic mstore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off;
    off = addr - BASE;
    for (int i = 0; i < msize(f3); i++) ref_mem[off + i] = wdata[8*i +: 8];
  endtask

  // One complete transaction; checks ACCESS-cycle SRAM signals and the response.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, output logic [31:0] got);
    bit          e;
    logic [31:0] exp;
    logic [31:0] off;
    int          csn0;
    e    = merr(we, f3, addr);
    exp  = (e || we) ? 32'd0 : mload(f3, addr);
    off  = addr - BASE;
    csn0 = csn_low_cycles;
    check("req_ready_idle", req_ready, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge CLK); #1;
    req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom);
    req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (!e) begin
      rsp_ready = 1'($urandom_range(0, 1));
      check("acc_csn", MEM_CSN, 32'd0);
      check("acc_wen", MEM_WEN, we ? 32'd0 : 32'd1);
      check("acc_addr", MEM_ADDR, 32'(off[AW+1:2]));
      check("acc_be", MEM_BE, we ? 32'(mbe(f3, addr)) : 32'd0);
      if (we) check("acc_di", MEM_DI, mdi(f3, wdata));
      check("acc_busy", {req_ready, rsp_valid}, 32'd0);
      if (we) mstore(f3, addr, wdata);
      @(posedge CLK); #1;
    end
    rsp_ready = 1'b0;
    got = rsp_rdata;
    check("rsp_valid", rsp_valid, 32'd1);
    check("rsp_err", rsp_err, 32'(e));
    check("rsp_rdata", rsp_rdata, exp);
    check("rsp_csn", MEM_CSN, 32'd1);
    check("rsp_req_ready", req_ready, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      check("hold_valid", rsp_valid, 32'd1);
      check("hold_rdata", rsp_rdata, exp);
      check("hold_req_ready", req_ready, 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    check("post_valid", rsp_valid, 32'd0);
    check("post_req_ready", req_ready, 32'd1);
    if (e) check("err_no_csn", 32'(csn_low_cycles - csn0), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    for (int i = 0; i < (1 << AW); i++) sram[i] = 32'd0;
    for (int i = 0; i < (4 << AW); i++) ref_mem[i] = 8'd0;
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req_ready", req_ready, 32'd1);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", rsp_err, 32'd0);
    check("rst_csn", MEM_CSN, 32'd1);
    check("rst_wen", MEM_WEN, 32'd1);
    check("rst_be", MEM_BE, 32'd0);
    check("rst_addr", MEM_ADDR, 32'd0);
    check("rst_di", MEM_DI, 32'd0);
    RST = 1'b0;

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, got);
    do_req(1'b0, 3'd2, 32'h10, 32'd0, 0, got);
    check("lw_deadbeef", got, 32'hDEADBEEF);

    do_req(1'b1, 3'd0, 32'h21, 32'h000000A5, 0, got);
    do_req(1'b1, 3'd1, 32'h22, 32'h00001234, 0, got);
    do_req(1'b0, 3'd2, 32'h20, 32'd0, 0, got);
    check("lw_merged", got, 32'h1234A500);

    do_req(1'b1, 3'd2, 32'h30, 32'h00008080, 0, got);
    do_req(1'b0, 3'd0, 32'h30, 32'd0, 0, got);  check("lb_sext", got, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h30, 32'd0, 0, got);  check("lbu_zext", got, 32'h00000080);
    do_req(1'b0, 3'd1, 32'h30, 32'd0, 0, got);  check("lh_sext", got, 32'hFFFF8080);
    do_req(1'b0, 3'd5, 32'h30, 32'd0, 1, got);  check("lhu_zext", got, 32'h00008080);

    // Error cases; the task also checks that the SRAM is never selected.
    do_req(1'b0, 3'd2, 32'h02, 32'd0, 0, got);
    do_req(1'b1, 3'd1, 32'h03, 32'hFFFF, 0, got);
    do_req(1'b0, 3'd2, BASE + 32'h4000, 32'd0, 0, got);
    do_req(1'b0, 3'd3, 32'h00, 32'd0, 0, got);
    do_req(1'b1, 3'd4, 32'h08, 32'h55, 0, got);

    do_req(1'b0, 3'd2, 32'h10, 32'd0, 3, got);
    check("lw_hold", got, 32'hDEADBEEF);

    // Reset raised during the ACCESS cycle of a store: write commits, no response.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h11111111;
    @(posedge CLK); #1;
    req_valid = 1'b0; RST = 1'b1;
    check("rsta_csn", MEM_CSN, 32'd0);
    mstore(3'd2, 32'h40, 32'h11111111);
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rsta_valid", rsp_valid, 32'd0);
    check("rsta_req_ready", req_ready, 32'd1);
    @(posedge CLK); #1;
    check("rsta_valid2", rsp_valid, 32'd0);
    do_req(1'b0, 3'd2, 32'h40, 32'd0, 0, got);
    check("rsta_lw", got, 32'h11111111);

    // Reset during RESP drops the pending response.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    check("rstr_valid_before", rsp_valid, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check("rstr_valid", rsp_valid, 32'd0);
    check("rstr_rdata", rsp_rdata, 32'd0);
    check("rstr_req_ready", req_ready, 32'd1);

    for (int n = 0; n < 120; n++) begin
      a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 255)) : $urandom;
      do_req(1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 2)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
